// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Ciphertext appears 10 cycles after the start edge; AES_en is ignored while busy.
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        BUSY
    } fsm_t;

    // Entry 0 sits in the top byte, so the bit offset is 2047 - 8*b, i.e. ~{b,000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[~{b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_t         fsm, fsm_nxt;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [3:0]   round;
    logic         start;
    logic         last;

    logic [127:0] sub_bytes, shift_rows, mix_cols, next_key, round_out;
    logic [31:0]  key_tmp;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        start   = 1'b0;
        last    = 1'b0;
        case (fsm)
            IDLE: begin
                if (AES_en) begin
                    start   = 1'b1;
                    fsm_nxt = BUSY;
                end
            end
            BUSY: begin
                if (round == 4'd10) begin
                    last    = 1'b1;
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Byte i of the block (row i%4, column i/4) lives at bits [127-8i -: 8].
    always_comb begin
        sub_bytes  = '0;
        shift_rows = '0;
        mix_cols   = '0;
        for (int i = 0; i < 16; i++) begin
            sub_bytes[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_cols[127-32*c -: 32] = mix_col(shift_rows[127-32*c -: 32]);
        end

        key_tmp = {sbox(rkey[23:16]), sbox(rkey[15:8]), sbox(rkey[7:0]), sbox(rkey[31:24])}
                ^ {rcon(round), 24'h000000};
        next_key[127:96] = rkey[127:96] ^ key_tmp;
        next_key[95:64]  = rkey[95:64]  ^ next_key[127:96];
        next_key[63:32]  = rkey[63:32]  ^ next_key[95:64];
        next_key[31:0]   = rkey[31:0]   ^ next_key[63:32];

        round_out = ((round == 4'd10) ? shift_rows : mix_cols) ^ next_key;
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state              <= '0;
            rkey               <= '0;
            round              <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= last;
            if (start) begin
                rkey  <= AES_key_in;
                state <= AES_data_in ^ AES_key_in;
                round <= 4'd1;
            end else if (fsm == BUSY) begin
                state <= round_out;
                rkey  <= next_key;
                round <= last ? 4'd0 : round + 4'd1;
                if (last) begin
                    AES_data_out <= round_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: directed FIPS-197 vectors plus random traffic against a
// byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         valid;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_tb [256];

    int           m_cnt  = 0;
    logic [127:0] m_out  = '0;
    logic [127:0] m_pend = '0;
    logic         m_vld  = 1'b0;

    aes_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (data_in),
        .AES_key_in         (key_in),
        .AES_data_out       (data_out),
        .AES_data_out_valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [31:0]  t;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]], sbox_tb[t[31:24]]}
                  ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r][c] = sbox_tb[st[r][(c+r)%4]];
            st = tmp;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[0][c]; a1 = st[1][c]; a2 = st[2][c]; a3 = st[3][c];
                    st[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = st[r][c];
        return res;
    endfunction

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_cnt = 0;
            m_out = '0;
            m_vld = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out = m_pend;
                    m_vld = 1'b1;
                end
            end else if (en) begin
                m_pend = aes_ref(data_in, key_in);
                m_cnt  = 10;
            end
        end
        check("vld", {127'b0, valid}, {127'b0, m_vld});
        check("dout", data_out, m_out);
    endtask

    task automatic run_block(input logic [127:0] k, input logic [127:0] d, output int lat);
        key_in  = k;
        data_in = d;
        en      = 1'b1;
        tick();
        en  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int strobes;
        int last_idx;
        logic [7:0] inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n   = 1'b0;
        en      = 1'b0;
        data_in = '0;
        key_in  = '0;
        #1;
        check("rst_dout", data_out, 128'h0);
        check("rst_vld", {127'b0, valid}, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, lat);
        check("t1_ct", data_out, 128'h3925841d02dc09fbdc118597196a0b32);
        check("t1_lat", 128'(lat), 128'd10);
        tick();
        check("t1_strobe_len", {127'b0, valid}, 128'h0);

        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, lat);
        check("t2_ct", data_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("t2_lat", 128'(lat), 128'd10);
        for (int i = 0; i < 6; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        check("t2_hold", data_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        key_in   = '0;
        data_in  = '0;
        en       = 1'b1;
        strobes  = 0;
        last_idx = -1;
        for (int i = 0; i < 51; i++) begin
            tick();
            if (valid) begin
                strobes++;
                check("t3_ct", data_out, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
                if (last_idx >= 0) check("t3_gap", 128'(i - last_idx), 128'd11);
                last_idx = i;
            end
        end
        check("t3_count", 128'(strobes), 128'd4);
        en = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        key_in  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        data_in = 128'h3243f6a8885a308d313198a2e0370734;
        en      = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            en = (i == 4);
            if (i == 3) data_in = 128'ha6f2daeb140fa720529e75d521cbc681;
            tick();
        end
        check("t4_ct", data_out, 128'h3925841d02dc09fbdc118597196a0b32);
        check("t4_vld", {127'b0, valid}, 128'h1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        key_in  = 128'h000102030405060708090a0b0c0d0e0f;
        data_in = 128'h00112233445566778899aabbccddeeff;
        en      = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", data_out, 128'h0);
        check("t5_rst_vld", {127'b0, valid}, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, lat);
        check("t5_ct", data_out, 128'h3925841d02dc09fbdc118597196a0b32);
        check("t5_lat", 128'(lat), 128'd10);

        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 2) == 0);
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            rst_n   = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 15; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only), used as the top-level crypto block.
- Captures a 128-bit plaintext and a 128-bit key on a start request.
- Computes one round per clock, expanding round keys on the fly.
- Presents the ciphertext with a one-cycle valid strobe.

Parameters:
- None. Key size is fixed at 128 bits, Nr = 10.

Ports:
- AES_clk  input  1  system clock; all state updates on its rising edge.
- AES_rst_n  input  1  reset, asynchronous, active-low.
- AES_en  input  1  start request, sampled on the rising edge.
- AES_data_in  input  128  plaintext; bits [127:120] = state byte 0 (row 0, col 0), column-major per FIPS-197.
- AES_key_in  input  128  cipher key, same byte order.
- AES_data_out  output  128  ciphertext, same byte order.
- AES_data_out_valid  output  1  one-cycle strobe marking new ciphertext.

Behaviour:
- Clock and reset: one clock, AES_clk. AES_rst_n is asynchronous and active-low.
- Reset values:
  - AES_data_out = 0, AES_data_out_valid = 0.
  - Internal state, round key and round counter = 0.
  - FSM = IDLE.
- FSM states are IDLE and BUSY.
- IDLE, edge with AES_en=1 (start edge E0):
  - Capture key.
  - state <= AES_data_in XOR AES_key_in (initial AddRoundKey).
  - round <= 1; go to BUSY.
- BUSY, edges E1..E9: apply SubBytes, ShiftRows, MixColumns, then AddRoundKey with round key r. r is derived from key r-1 via RotWord, SubWord and Rcon (01,02,04,08,10,20,40,80,1b,36). round increments.
- BUSY, edge E10:
  - Final round without MixColumns.
  - Result loads into AES_data_out; AES_data_out_valid <= 1; return to IDLE.
- Valid strobe: AES_data_out_valid is high for exactly the one cycle after E10 and drops at E11.
- Output hold: AES_data_out holds its value until the next completion or a reset.
- Latency: ciphertext visible 10 clock cycles after the start edge.
- Throughput: one block per 11 cycles.
- Back-to-back operation: if AES_en is still high at E11, a new encryption starts at E11 using the inputs present then. A continuously asserted AES_en therefore yields a valid strobe every 11 cycles.
- Input sampling: AES_data_in and AES_key_in are sampled only at a start edge. Changes while BUSY are ignored, and AES_en is ignored while BUSY.
- Deassertion: deasserting AES_en mid-operation does not abort; the block completes normally.
- Reset mid-operation: abort immediately, all outputs and state return to reset values, and no valid strobe is produced.
- Structure:
  - S-box is a shared combinational function.
  - 16 instances serve the data path and 4 serve key expansion.
  - No pipelining beyond the single round register.

Test Plan:
1. Reset, then E0 with key 2b7e151628aed2a6abf7158809cf4f3c and data 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32 with valid high for one cycle, exactly 10 cycles after E0.
2. Key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Then drop AES_en -> output holds and valid stays 0.
3. All-zero key and data -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Keep AES_en high for 51 cycles -> repeated identical results, valid strobe every 11 cycles.
4. Start with the case 1 vectors, then change AES_data_in to a6f2daeb140fa720529e75d521cbc681 at cycle 3 -> output is still 3925841d02dc09fbdc118597196a0b32.
5. Assert AES_rst_n=0 at cycle 5 of an operation -> outputs 0 immediately and no valid strobe. After release, a fresh start produces correct results.
